// File: rtl/serial_sub_ctrl_pkg.sv
// Purpose: shared state encoding and width limits for the bit-serial subtractor.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package serial_sub_pkg;

    // Controller states; the spare code 2'd3 is treated as IDLE by the FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Legal operand widths.
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    // Counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Purpose: request/result bundle between a host and the serial subtractor.
// Latency: n/a (wiring only).
// Backpressure: none; start is a level request sampled by the controller.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    // Host side drives the request and operands.
    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    // Controller side returns status and result.
    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_sub_ctrl_bit_sub_cell.sv
// Purpose: 1-bit full subtractor (a - b - bin) from two half-subtract stages.
// Latency: combinational.
// Backpressure: n/a.
module bit_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);
    logic d1;
    logic b1;
    logic b2;

    // First half-subtract a - b, second subtracts the incoming borrow.
    always_comb begin
        d1 = a ^ b;
        b1 = ~a & b;
        d  = d1 ^ bin;
        b2 = ~d1 & bin;
        bo = b1 | b2;
    end
endmodule

// File: rtl/serial_sub_ctrl.sv
// Purpose: bit-serial WIDTH-bit subtract controller, LSB first, one bit per clock.
// Latency: done pulses WIDTH+1 edges after the accepting edge's request cycle.
// Backpressure: start ignored while busy; held start in DONE chains the next op.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_sub_ctrl_if.slave    bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             busy_q;
    logic             done_q;
    logic             bout_q;
    logic             cell_d;
    logic             cell_bo;

    // Single arithmetic cell works on the current LSB of the operand shifters.
    bit_sub_cell u_cell (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .bin (borrow),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    // Sequencer: operand capture, per-bit shifting, and registered status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            diff_q <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        diff_q <= '0;
                        cnt    <= '0;
                        borrow <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Result bits enter at the MSB so the LSB lands at bit 0 last.
                    diff_q <= (diff_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
                    borrow <= cell_bo;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bout_q <= cell_bo;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.busy = busy_q;
        bus.done = done_q;
        bus.diff = diff_q;
        bus.bout = bout_q;
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Purpose: directed self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1.
// Latency: checks done timing, busy length and results against hand-computed values.
// Backpressure: exercises ignored start during RUN and back-to-back held start.
module tb_serial_sub_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    serial_sub_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_sub_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    serial_sub_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; optionally pulses start mid-RUN with other operands.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input bit poke);
        int busy_cnt;
        int done_at;
        int dones;
        busy_cnt = 0;
        done_at  = -1;
        dones    = 0;
        bus8.a = a;
        bus8.b = b;
        bus8.start = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) bus8.start = 1'b0;
            if (poke && i == 4) begin
                bus8.a = 8'hAA;
                bus8.b = 8'h11;
                bus8.start = 1'b1;
            end
            if (poke && i == 5) bus8.start = 1'b0;
            if (bus8.busy) busy_cnt++;
            if (bus8.done) begin
                dones++;
                if (done_at < 0) begin
                    done_at = i;
                    chk({tag, "_diff"}, 32'(bus8.diff), 32'(ed));
                    chk({tag, "_bout"}, 32'(bus8.bout), 32'(eb));
                end
            end
        end
        chk({tag, "_done_at"}, 32'(done_at), 32'd9);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({tag, "_done_pulses"}, 32'(dones), 32'd1);
    endtask

    // One WIDTH=1 operation.
    task automatic run1(input string tag, input logic a, input logic b, input logic [1:0] exp);
        int done_at;
        int busy_cnt;
        done_at  = -1;
        busy_cnt = 0;
        bus1.a = a;
        bus1.b = b;
        bus1.start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) bus1.start = 1'b0;
            if (bus1.busy) busy_cnt++;
            if (bus1.done && done_at < 0) begin
                done_at = i;
                chk({tag, "_res"}, 32'({bus1.bout, bus1.diff}), 32'(exp));
            end
        end
        chk({tag, "_done_at"}, 32'(done_at), 32'd2);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd1);
    endtask

    initial begin
        int done_at;
        int dones;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_done", 32'(bus8.done), 32'd0);
        chk("rst_diff", 32'(bus8.diff), 32'd0);
        chk("rst_bout", 32'(bus8.bout), 32'd0);
        chk("rst1_res", 32'({bus1.bout, bus1.diff}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic and borrow cases.
        run8("t1", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run8("t2a", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run8("t2b", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run8("t2c", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);

        // Start pulsed mid-RUN must not disturb the operation in flight.
        run8("t3", 8'h05, 8'h03, 8'h02, 1'b0, 1'b1);

        // Start held high across two operations.
        done_at = -1;
        dones = 0;
        bus8.a = 8'h10;
        bus8.b = 8'h01;
        bus8.start = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                bus8.a = 8'h20;
                bus8.b = 8'h30;
            end
            if (i == 10) bus8.start = 1'b0;
            if (bus8.done) begin
                dones++;
                if (dones == 1) begin
                    chk("t4_first_at", 32'(i), 32'd9);
                    chk("t4_first_diff", 32'(bus8.diff), 32'h0F);
                    chk("t4_first_bout", 32'(bus8.bout), 32'd0);
                    done_at = i;
                end else if (dones == 2) begin
                    chk("t4_second_gap", 32'(i - done_at), 32'd9);
                    chk("t4_second_diff", 32'(bus8.diff), 32'hF0);
                    chk("t4_second_bout", 32'(bus8.bout), 32'd1);
                end
            end
        end
        chk("t4_done_pulses", 32'(dones), 32'd2);

        // Reset in the middle of RUN aborts without a done pulse.
        bus8.a = 8'h55;
        bus8.b = 8'h22;
        bus8.start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) bus8.start = 1'b0;
        end
        chk("t5_busy_before", 32'(bus8.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(bus8.busy), 32'd0);
        chk("t5_done", 32'(bus8.done), 32'd0);
        chk("t5_diff", 32'(bus8.diff), 32'd0);
        chk("t5_bout", 32'(bus8.bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (bus8.done || bus8.busy) dones++;
        end
        chk("t5_no_activity", 32'(dones), 32'd0);
        run8("t5_next", 8'h07, 8'h02, 8'h05, 1'b0, 1'b0);

        // Single-bit instance, full truth table.
        run1("t6_00", 1'b0, 1'b0, 2'b00);
        run1("t6_01", 1'b0, 1'b1, 2'b11);
        run1("t6_10", 1'b1, 1'b0, 2'b01);
        run1("t6_11", 1'b1, 1'b1, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
